alu_issue_stage: RTL and testbench

- Decode-to-execute issue register that produces every control and operand input the ALU consumes.
- It decodes a 32-bit MIPS-style instruction into ALUOp, ex_cmd, flag and branch, and selects the two ALU operands.
- Results are registered in an ID/EX pipeline slot with a valid/ready handshake, stall and flush.
- It sits between the register-file read in decode and the ALU in execute.

---
 rtl/alu_issue_stage.sv | 256 +++++++++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// ID/EX issue register: decodes a MIPS-style instruction into ALU controls and
// operands, and holds the result in a single valid/ready pipeline slot.
module alu_issue_stage #(
  parameter int WIDTH     = 32,
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instr_d,
  input  logic [WIDTH-1:0]     rs_data_d,
  input  logic [WIDTH-1:0]     rt_data_d,
  input  logic                 flush_e,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     input1,
  output logic [WIDTH-1:0]     input2,
  output logic                 flag,
  output logic [4:0]           ex_cmd,
  output logic [1:0]           ALUOp,
  output logic                 branchD,
  output logic                 branch_ne,
  output logic                 reg_write,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [4:0]           dest_reg,
  output logic                 illegal,
  output logic [ILL_CNT_W-1:0] illegal_count
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [5:0]  opcode, funct;
  logic [4:0]  rt_f, rd_f, shamt;
  logic [15:0] imm;
  logic        unused_rs_field;

  assign opcode          = instr_d[31:26];
  assign rt_f            = instr_d[20:16];
  assign rd_f            = instr_d[15:11];
  assign shamt           = instr_d[10:6];
  assign funct           = instr_d[5:0];
  assign imm             = instr_d[15:0];
  assign unused_rs_field = ^instr_d[25:21];

  function automatic logic [WIDTH-1:0] sext_imm(input logic [15:0] v);
    logic signed [WIDTH-1:0] s;
    s = {{(WIDTH-16){v[15]}}, v};
    return s;
  endfunction

  function automatic logic [WIDTH-1:0] zext_imm(input logic [15:0] v);
    return {{(WIDTH-16){1'b0}}, v};
  endfunction

  function automatic logic [WIDTH-1:0] zext_shamt(input logic [4:0] v);
    return {{(WIDTH-5){1'b0}}, v};
  endfunction

  logic [WIDTH-1:0] dec_in1, dec_in2;
  logic             dec_flag, dec_br, dec_bne, dec_wb, dec_mr, dec_mw, dec_ill;
  logic [4:0]       dec_cmd, dec_dest;
  logic [1:0]       dec_aluop;

  always_comb begin
    dec_in1   = rs_data_d;
    dec_in2   = rt_data_d;
    dec_flag  = 1'b0;
    dec_cmd   = 5'h00;
    dec_aluop = 2'd0;
    dec_br    = 1'b0;
    dec_bne   = 1'b0;
    dec_wb    = 1'b0;
    dec_mr    = 1'b0;
    dec_mw    = 1'b0;
    dec_dest  = 5'd0;
    dec_ill   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec_aluop = 2'd2;
        dec_wb    = 1'b1;
        dec_dest  = rd_f;
        case (funct)
          6'h20, 6'h22, 6'h2A: begin
            dec_cmd  = funct[4:0];
            dec_flag = 1'b1;
          end
          6'h21, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2B: dec_cmd = funct[4:0];
          // Shifts operate on rt; the shift amount travels as operand B.
          6'h00, 6'h02, 6'h03: begin
            dec_cmd = {1'b1, funct[3:0]};
            dec_in1 = rt_data_d;
            dec_in2 = zext_shamt(shamt);
          end
          default: dec_ill = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        dec_aluop = opcode[1] ? 2'd1 : 2'd0;
        dec_cmd   = opcode[1] ? {1'b0, opcode[3:0]} : {4'd0, opcode[0]};
        dec_flag  = ~opcode[0];
        dec_in2   = sext_imm(imm);
        dec_wb    = 1'b1;
        dec_dest  = rt_f;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        dec_aluop = 2'd3;
        dec_cmd   = {2'b00, opcode[2:0]};
        dec_in2   = zext_imm(imm);
        dec_wb    = 1'b1;
        dec_dest  = rt_f;
      end
      OP_LW, OP_SW: begin
        dec_flag = 1'b1;
        dec_in2  = sext_imm(imm);
        dec_mr   = (opcode == OP_LW);
        dec_mw   = (opcode == OP_SW);
        dec_wb   = (opcode == OP_LW);
        dec_dest = (opcode == OP_LW) ? rt_f : 5'd0;
      end
      OP_BEQ, OP_BNE: begin
        dec_aluop = 2'd1;
        dec_cmd   = 5'h02;
        dec_flag  = 1'b1;
        dec_br    = 1'b1;
        dec_bne   = opcode[0];
      end
      default: dec_ill = 1'b1;
    endcase
    // Illegal ops issue as a bubble with no side effects.
    if (dec_ill) begin
      dec_aluop = 2'd0;
      dec_cmd   = 5'h00;
      dec_flag  = 1'b0;
      dec_wb    = 1'b0;
      dec_dest  = 5'd0;
    end
  end

  logic                 valid_q, valid_d;
  logic [WIDTH-1:0]     in1_q, in1_d, in2_q, in2_d;
  logic                 flag_q, flag_d, br_q, br_d, bne_q, bne_d;
  logic                 rw_q, rw_d, mr_q, mr_d, mw_q, mw_d, ill_q, ill_d;
  logic [4:0]           cmd_q, cmd_d, dest_q, dest_d;
  logic [1:0]           aluop_q, aluop_d;
  logic [ILL_CNT_W-1:0] cnt_q, cnt_d;
  logic                 accept;

  assign in_ready = rst_n && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    flag_d  = flag_q;
    cmd_d   = cmd_q;
    aluop_d = aluop_q;
    br_d    = br_q;
    bne_d   = bne_q;
    rw_d    = rw_q;
    mr_d    = mr_q;
    mw_d    = mw_q;
    dest_d  = dest_q;
    ill_d   = ill_q;
    cnt_d   = cnt_q;
    if (flush_e) begin
      valid_d = 1'b0;
      rw_d    = 1'b0;
      mr_d    = 1'b0;
      mw_d    = 1'b0;
      br_d    = 1'b0;
      ill_d   = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      in1_d   = dec_in1;
      in2_d   = dec_in2;
      flag_d  = dec_flag;
      cmd_d   = dec_cmd;
      aluop_d = dec_aluop;
      br_d    = dec_br;
      bne_d   = dec_bne;
      rw_d    = dec_wb && (dec_dest != 5'd0);
      mr_d    = dec_mr;
      mw_d    = dec_mw;
      dest_d  = dec_dest;
      ill_d   = dec_ill;
      if (dec_ill && (cnt_q != {ILL_CNT_W{1'b1}}))
        cnt_d = cnt_q + {{(ILL_CNT_W-1){1'b0}}, 1'b1};
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      in1_q   <= '0;
      in2_q   <= '0;
      flag_q  <= 1'b0;
      cmd_q   <= 5'h00;
      aluop_q <= 2'd0;
      br_q    <= 1'b0;
      bne_q   <= 1'b0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      dest_q  <= 5'd0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      flag_q  <= flag_d;
      cmd_q   <= cmd_d;
      aluop_q <= aluop_d;
      br_q    <= br_d;
      bne_q   <= bne_d;
      rw_q    <= rw_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
      dest_q  <= dest_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid     = valid_q;
  assign input1        = in1_q;
  assign input2        = in2_q;
  assign flag          = flag_q;
  assign ex_cmd        = cmd_q;
  assign ALUOp         = aluop_q;
  assign branchD       = br_q;
  assign branch_ne     = bne_q;
  assign reg_write     = rw_q;
  assign mem_read      = mr_q;
  assign mem_write     = mw_q;
  assign dest_reg      = dest_q;
  assign illegal       = ill_q;
  assign illegal_count = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: randomized instructions against a
// table-level decode model, plus directed reset/stall/flush/saturation cases.
module tb_alu_issue_stage;
  localparam int WIDTH     = 32;
  localparam int ILL_CNT_W = 8;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, flush_e, out_valid, out_ready;
  logic [31:0] instr_d, rs_data_d, rt_data_d, input1, input2;
  logic        flag, branchD, branch_ne, reg_write, mem_read, mem_write, illegal;
  logic [4:0]  ex_cmd, dest_reg;
  logic [1:0]  ALUOp;
  logic [7:0]  illegal_count;

  always #5 clk = ~clk;

  alu_issue_stage #(.WIDTH(WIDTH), .ILL_CNT_W(ILL_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr_d(instr_d), .rs_data_d(rs_data_d), .rt_data_d(rt_data_d),
    .flush_e(flush_e), .out_valid(out_valid), .out_ready(out_ready),
    .input1(input1), .input2(input2), .flag(flag), .ex_cmd(ex_cmd),
    .ALUOp(ALUOp), .branchD(branchD), .branch_ne(branch_ne),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .dest_reg(dest_reg), .illegal(illegal), .illegal_count(illegal_count)
  );

  typedef struct {
    logic [31:0] in1, in2;
    logic        flag, br, bne, rw, mr, mw, ill, chk_alu;
    logic [4:0]  cmd, dest;
    logic [1:0]  aluop;
  } exp_t;

  exp_t q[$];
  exp_t te, me;
  int   vectors = 0, miscompares = 0;
  int   ill_model = 0;
  bit   ctrl_zero = 1'b1;
  bit   rand_ready = 1'b0, rand_flush = 1'b0, flush_force = 1'b0;
  logic ready_val = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference decode written from the instruction table with plain arithmetic.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    exp_t e;
    int op, fn, imm;
    bit wb, legal;
    op = int'(ins[31:26]); fn = int'(ins[5:0]); imm = int'(ins[15:0]);
    e = '{default: '0};
    e.in1 = rs; e.in2 = rt; e.chk_alu = 1'b1;
    wb = 1'b0; legal = 1'b1;
    if (op == 0) begin
      e.aluop = 2'd2; e.dest = ins[15:11]; wb = 1'b1;
      if (fn inside {'h20, 'h21, 'h22, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h2B}) begin
        e.cmd  = 5'(fn - 'h20);
        e.flag = (fn == 'h20 || fn == 'h22 || fn == 'h2A);
      end else if (fn == 0 || fn == 2 || fn == 3) begin
        e.cmd = 5'(fn + 'h10); e.in1 = rt; e.in2 = 32'(int'(ins[10:6]));
      end else legal = 1'b0;
    end else if (op >= 8 && op <= 11) begin
      e.aluop = (op >= 10) ? 2'd1 : 2'd0;
      e.cmd   = (op >= 10) ? 5'(op) : 5'(op - 8);
      e.flag  = (op % 2 == 0);
      e.in2   = 32'(imm) - ((imm >= 32768) ? 32'd65536 : 32'd0);
      wb = 1'b1; e.dest = ins[20:16];
    end else if (op >= 12 && op <= 14) begin
      e.aluop = 2'd3; e.cmd = 5'(op - 8); e.in2 = 32'(imm);
      wb = 1'b1; e.dest = ins[20:16];
    end else if (op == 'h23 || op == 'h2B) begin
      e.flag = 1'b1;
      e.in2  = 32'(imm) - ((imm >= 32768) ? 32'd65536 : 32'd0);
      if (op == 'h23) begin e.mr = 1'b1; wb = 1'b1; e.dest = ins[20:16]; end
      else e.mw = 1'b1;
    end else if (op == 4 || op == 5) begin
      e.aluop = 2'd1; e.cmd = 5'd2; e.flag = 1'b1; e.br = 1'b1; e.bne = (op == 5);
    end else legal = 1'b0;
    if (!legal) begin
      e = '{default: '0};
      e.ill = 1'b1;
    end
    e.rw = legal && wb && (e.dest != 5'd0);
    return e;
  endfunction

  // Issue tracker: models the slot handshake at each edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete(); ill_model = 0; ctrl_zero = 1'b1;
    end else if (flush_e) begin
      q.delete(); ctrl_zero = 1'b1;
    end else if (in_valid && q.size() == 0) begin
      te = model(instr_d, rs_data_d, rt_data_d);
      if (te.ill && ill_model < 255) ill_model++;
      q.push_back(te);
      ctrl_zero = 1'b0;
    end
  end

  // Monitor: compares whatever the slot presents, pops when it is consumed.
  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(rst_n && (q.size() == 0 || out_ready)));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("illegal_count", 32'(illegal_count), 32'(ill_model));
    if (q.size() != 0) begin
      me = q[0];
      chk("illegal", 32'(illegal), 32'(me.ill));
      chk("reg_write", 32'(reg_write), 32'(me.rw));
      chk("mem_read", 32'(mem_read), 32'(me.mr));
      chk("mem_write", 32'(mem_write), 32'(me.mw));
      chk("branchD", 32'(branchD), 32'(me.br));
      chk("dest_reg", 32'(dest_reg), 32'(me.dest));
      if (me.br) chk("branch_ne", 32'(branch_ne), 32'(me.bne));
      if (me.chk_alu) begin
        chk("ALUOp", 32'(ALUOp), 32'(me.aluop));
        chk("ex_cmd", 32'(ex_cmd), 32'(me.cmd));
        chk("flag", 32'(flag), 32'(me.flag));
        chk("input1", input1, me.in1);
        chk("input2", input2, me.in2);
      end
      if (rst_n && out_ready && !flush_e) void'(q.pop_front());
    end else if (ctrl_zero) begin
      chk("idle_ctrl", 32'({reg_write, mem_read, mem_write, branchD, illegal}), 32'd0);
    end
  end

  // Downstream behaviour: ready and flush, updated just after each edge.
  initial begin
    out_ready = 1'b1;
    flush_e   = 1'b0;
    forever begin
      @(posedge clk); #2;
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_val;
      flush_e   = flush_force || (rand_flush && $urandom_range(0, 15) == 0);
    end
  end

  task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    int  tries;
    bit  acc;
    tries = 0;
    instr_d = ins; rs_data_d = a; rt_data_d = b; in_valid = 1'b1;
    do begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      tries++;
    end while (!acc && tries < 200);
    if (!acc) begin
      vectors++; miscompares++;
      $display("FAIL issue_timeout: got in_ready=0 for %0d cycles, expected acceptance", tries);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Issue one instruction and check the slot against fixed values.
  task automatic directed(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] aop, input logic [4:0] cmd, input logic fl,
                          input logic [31:0] i1, input logic [31:0] i2,
                          input logic [4:0] dst, input logic rw, input logic br);
    issue(ins, a, b);
    in_valid = 1'b0;
    @(negedge clk);
    chk("d_out_valid", 32'(out_valid), 32'd1);
    chk("d_ALUOp", 32'(ALUOp), 32'(aop));
    chk("d_ex_cmd", 32'(ex_cmd), 32'(cmd));
    chk("d_flag", 32'(flag), 32'(fl));
    chk("d_input1", input1, i1);
    chk("d_input2", input2, i2);
    chk("d_dest_reg", 32'(dest_reg), 32'(dst));
    chk("d_reg_write", 32'(reg_write), 32'(rw));
    chk("d_branchD", 32'(branchD), 32'(br));
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0]  fns [14] = '{6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27,
                              6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h01, 6'h2C};
    logic [5:0]  ops [13] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E,
                              6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F};
    logic [31:0] r;
    int sel;
    r = $urandom;
    sel = $urandom_range(0, 5);
    if (sel <= 1) begin
      r[31:26] = 6'h00; r[5:0] = fns[$urandom_range(0, 13)];
    end else if (sel <= 3) begin
      r[31:26] = ops[$urandom_range(0, 12)];
    end else if (sel == 4) begin
      r[31:26] = ops[$urandom_range(0, 12)]; r[20:11] = 10'd0;
    end else begin
      r[31:26] = 6'($urandom);
    end
    return r;
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; instr_d = 32'h00221820;
    rs_data_d = 32'd1; rt_data_d = 32'd2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_outputs", {out_valid, flag, ex_cmd, ALUOp, branchD, branch_ne, reg_write,
                        mem_read, mem_write, dest_reg, illegal, 8'd0}, 32'd0);
    chk("rst_operands", input1 | input2, 32'd0);
    chk("rst_count", 32'(illegal_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    directed(32'h00221820, 32'd1, 32'd2, 2'd2, 5'h00, 1'b1, 32'd1, 32'd2, 5'd3, 1'b1, 1'b0);
    directed(32'h00221822, 32'd9, 32'd4, 2'd2, 5'h02, 1'b1, 32'd9, 32'd4, 5'd3, 1'b1, 1'b0);
    directed(32'h00021900, 32'd7, 32'd2, 2'd2, 5'h10, 1'b0, 32'd2, 32'd4, 5'd3, 1'b1, 1'b0);
    directed(32'h2025FFFC, 32'd1, 32'd0, 2'd0, 5'h00, 1'b1, 32'd1, 32'hFFFFFFFC, 5'd5, 1'b1, 1'b0);
    directed(32'h3425FFFC, 32'd1, 32'd0, 2'd3, 5'h05, 1'b0, 32'd1, 32'h0000FFFC, 5'd5, 1'b1, 1'b0);
    directed(32'h10220003, 32'd6, 32'd8, 2'd1, 5'h02, 1'b1, 32'd6, 32'd8, 5'd0, 1'b0, 1'b1);

    // Stall three cycles with a new offer pending, then flush while stalled.
    idle(2);
    ready_val = 1'b0;
    issue(32'h00A63820, 32'h11, 32'h22);
    instr_d = 32'h2025FFFC; rs_data_d = 32'h33; rt_data_d = 32'h44; in_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    in_valid = 1'b0; flush_force = 1'b1;
    @(posedge clk); #1;
    flush_force = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_reg_write", 32'(reg_write), 32'd0);
    @(posedge clk); #1;

    // Reset arriving mid-stall discards the slot.
    issue(32'h8C450010, 32'h100, 32'h0);
    idle(2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; ready_val = 1'b1;
    directed(32'h00221820, 32'd5, 32'd6, 2'd2, 5'h00, 1'b1, 32'd5, 32'd6, 5'd3, 1'b1, 1'b0);

    rand_ready = 1'b1; rand_flush = 1'b1;
    for (int i = 0; i < 400; i++) begin
      issue(rand_instr(), $urandom, $urandom);
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    idle(3);

    rand_ready = 1'b0; rand_flush = 1'b0; ready_val = 1'b1;
    for (int i = 0; i < 300; i++) issue(32'hFC000000, $urandom, $urandom);
    idle(2);
    @(negedge clk);
    chk("ill_saturated", 32'(illegal_count), 32'd255);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
